// File: rtl/tcon_pkg.sv
// Shared types and source encodings for the two-source arbiter and its mux.
package tcon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_S = 2'd2
  } tcon_arb_state_e;

  localparam logic SRC_A = 1'b1;
  localparam logic SRC_S = 1'b0;

endpackage

// File: rtl/tcon_mux.sv
// Combinational WIDTH-bit 2:1 source mux: sel=1 passes A, sel=0 passes S.
module tcon_mux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] s_data,
  input  logic             sel,
  output logic [WIDTH-1:0] mux_data
);

  assign mux_data = sel ? a_data : s_data;

endmodule

// File: rtl/tcon_arb.sv
// Round-robin, burst-limited arbiter for sources A and S; steers tcon_mux and
// registers the selected word into a single-entry output stage.
module tcon_arb
  import tcon_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  tcon_arb_state_e state_q;
  logic            sel_q;
  logic            last_src_q;
  logic [CntW-1:0] burst_cnt_q;
  logic            out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic            out_src_q;

  logic [WIDTH-1:0] mux_data;
  logic            space, a_xfer, s_xfer, xfer;
  logic [CntW-1:0] cnt_nxt;
  logic            burst_done;
  logic            cur_src, x_valid, y_valid;
  logic            enter, enter_src, go_idle, cnt_clr, cnt_inc;

  tcon_mux #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a_data  (a_data),
    .s_data  (s_data),
    .sel     (sel_q),
    .mux_data(mux_data)
  );

  // Readies are gated by reset so nothing is accepted while reset is held.
  assign space   = !out_valid_q || out_ready;
  assign a_ready = rst_n && (state_q == GRANT_A) && space;
  assign s_ready = rst_n && (state_q == GRANT_S) && space;
  assign a_xfer  = a_valid && a_ready;
  assign s_xfer  = s_valid && s_ready;
  assign xfer    = a_xfer || s_xfer;

  assign cnt_nxt    = burst_cnt_q + CntW'(1);
  assign burst_done = (cnt_nxt == CntW'(MAX_BURST));

  always_comb begin
    enter     = 1'b0;
    enter_src = SRC_A;
    go_idle   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cur_src   = (state_q == GRANT_A) ? SRC_A : SRC_S;
    x_valid   = cur_src ? a_valid : s_valid;
    y_valid   = cur_src ? s_valid : a_valid;
    unique case (state_q)
      IDLE: begin
        // On a tie the source that was not granted last wins.
        if (a_valid && (!s_valid || last_src_q == SRC_S)) begin
          enter     = 1'b1;
          enter_src = SRC_A;
        end else if (s_valid) begin
          enter     = 1'b1;
          enter_src = SRC_S;
        end
      end
      GRANT_A, GRANT_S: begin
        if (!x_valid) begin
          cnt_clr = 1'b1;
          if (y_valid) begin
            enter     = 1'b1;
            enter_src = !cur_src;
          end else begin
            go_idle = 1'b1;
          end
        end else if (xfer) begin
          if (burst_done) begin
            // A lone requester keeps the grant; the count just restarts.
            cnt_clr = 1'b1;
            if (y_valid) begin
              enter     = 1'b1;
              enter_src = !cur_src;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_src_q  <= SRC_S;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mux_data;
        out_src_q   <= cur_src;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (enter) begin
        state_q     <= enter_src ? GRANT_A : GRANT_S;
        sel_q       <= enter_src;
        last_src_q  <= enter_src;
        burst_cnt_q <= '0;
      end else if (go_idle) begin
        state_q     <= IDLE;
        burst_cnt_q <= '0;
      end else if (cnt_clr) begin
        burst_cnt_q <= '0;
      end else if (cnt_inc) begin
        burst_cnt_q <= cnt_nxt;
      end
    end
  end

  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_tcon_arb.sv
// Self-checking bench for tcon_arb: directed scenarios plus a randomized run
// checked against source-order scoreboards and a burst-fairness rule.
module tb_tcon_arb;

  localparam int MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, s_valid, out_ready;
  logic [7:0] a_data, s_data;
  logic       a_ready, s_ready, sel, out_valid, out_src;
  logic [7:0] out_data;

  logic [7:0] aq[$];
  logic [7:0] sq[$];
  logic [8:0] acc_log[$];
  int         acc_cyc[$];
  logic [8:0] out_log[$];
  int         a_p, s_p, cyc;
  int         n_checks = 0;
  int         n_pass = 0;

  tcon_arb #(
    .WIDTH    (8),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Sources hold valid/data until accepted; a fresh word is offered with
  // probability a_p/s_p percent.
  task automatic drive(input logic af, input logic sf);
    if (!(a_valid && !af)) a_valid = (aq.size() > 0) && ($urandom_range(99) < a_p);
    if (!(s_valid && !sf)) s_valid = (sq.size() > 0) && ($urandom_range(99) < s_p);
    a_data = (aq.size() > 0) ? aq[0] : 8'h00;
    s_data = (sq.size() > 0) ? sq[0] : 8'h00;
  endtask

  // Called between negedge and posedge: logs handshakes, advances one cycle.
  task automatic tick();
    logic af, sf;
    af = a_valid && a_ready;
    sf = s_valid && s_ready;
    if (rst_n && out_valid && out_ready) out_log.push_back({out_src, out_data});
    if (af) begin acc_log.push_back({1'b1, a_data}); acc_cyc.push_back(cyc); end
    if (sf) begin acc_log.push_back({1'b0, s_data}); acc_cyc.push_back(cyc); end
    @(posedge clk); #1;
    cyc++;
    if (af) void'(aq.pop_front());
    if (sf) void'(sq.pop_front());
    drive(af, sf);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a_valid = 1'b0; s_valid = 1'b0; out_ready = 1'b1;
    a_data = 8'h00; s_data = 8'h00; a_p = 100; s_p = 100;
    aq.delete(); sq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc_log.delete(); acc_cyc.delete(); out_log.delete(); cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b1; s_valid = 1'b1; out_ready = 1'b1;
    a_data = 8'hFF; s_data = 8'hEE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (a_ready !== 1'b0) $display("FAIL reset_a_ready got %0b want 0", a_ready); else n_pass++;
    n_checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready got %0b want 0", s_ready); else n_pass++;
    n_checks++; if (sel !== 1'b0) $display("FAIL reset_sel got %0b want 0", sel); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", out_data); else n_pass++;
    n_checks++; if (out_src !== 1'b0) $display("FAIL reset_out_src got %0b want 0", out_src); else n_pass++;
  endtask

  task automatic test_a_only();
    logic [7:0] exp[3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    do_reset();
    aq.push_back(8'h11); aq.push_back(8'h22); aq.push_back(8'h33);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_checks++; if (a_ready !== 1'b0) $display("FAIL a_only_idle_ready got %0b want 0", a_ready); else n_pass++;
      end
      if (i >= 1 && i <= 3) begin
        n_checks++; if (a_ready !== 1'b1) $display("FAIL a_only_ready c%0d got %0b want 1", i, a_ready); else n_pass++;
      end
      if (i >= 1 && i <= 5) begin
        n_checks++; if (sel !== 1'b1) $display("FAIL a_only_sel c%0d got %0b want 1", i, sel); else n_pass++;
      end
      if (i >= 2 && i <= 4) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp[i-2] || out_src !== 1'b1)
          $display("FAIL a_only_out c%0d got v%0b %h src%0b want v1 %h src1", i, out_valid, out_data, out_src, exp[i-2]);
        else n_pass++;
      end
      if (i == 5) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL a_only_drain got %0b want 0", out_valid); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_fair();
    logic [8:0] exp[12];
    for (int i = 0; i < 4; i++) begin exp[i] = {1'b1, 8'hA0 + 8'(i)}; exp[4+i] = {1'b0, 8'h50 + 8'(i)}; end
    for (int i = 0; i < 2; i++) begin exp[8+i] = {1'b1, 8'hA4 + 8'(i)}; exp[10+i] = {1'b0, 8'h54 + 8'(i)}; end
    do_reset();
    for (int i = 0; i < 6; i++) begin aq.push_back(8'hA0 + 8'(i)); sq.push_back(8'h50 + 8'(i)); end
    drive(1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_log.size() >= 12) break;
      tick();
    end
    n_checks++; if (acc_log.size() != 12) $display("FAIL fair_acc_count got %0d want 12", acc_log.size()); else n_pass++;
    n_checks++; if (out_log.size() != 12) $display("FAIL fair_out_count got %0d want 12", out_log.size()); else n_pass++;
    for (int i = 0; i < 12 && i < out_log.size(); i++) begin
      n_checks++; if (out_log[i] !== exp[i]) $display("FAIL fair_order[%0d] got %h want %h", i, out_log[i], exp[i]); else n_pass++;
    end
    if (acc_cyc.size() >= 9) begin
      n_checks++; if (acc_cyc[4] != acc_cyc[3] + 1) $display("FAIL fair_handover1 got gap %0d want 1", acc_cyc[4] - acc_cyc[3]); else n_pass++;
      n_checks++; if (acc_cyc[8] != acc_cyc[7] + 1) $display("FAIL fair_handover2 got gap %0d want 1", acc_cyc[8] - acc_cyc[7]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    aq.push_back(8'h5A); aq.push_back(8'h6B);
    out_ready = 1'b0;
    drive(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 1 || i == 5) begin
        n_checks++; if (a_ready !== 1'b1) $display("FAIL bp_ready c%0d got %0b want 1", i, a_ready); else n_pass++;
      end
      if (i >= 2 && i <= 5) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A)
          $display("FAIL bp_hold c%0d got v%0b %h want v1 5a", i, out_valid, out_data);
        else n_pass++;
      end
      if (i >= 2 && i <= 4) begin
        n_checks++; if (a_ready !== 1'b0) $display("FAIL bp_stall c%0d got %0b want 0", i, a_ready); else n_pass++;
      end
      if (i == 6) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h6B || out_src !== 1'b1)
          $display("FAIL bp_next got v%0b %h src%0b want v1 6b src1", out_valid, out_data, out_src);
        else n_pass++;
        n_checks++; if (out_log.size() != 1 || out_log[0] !== 9'h15A)
          $display("FAIL bp_drained got %0d words want one 15a", out_log.size());
        else n_pass++;
      end
      tick();
      if (i == 4) out_ready = 1'b1;
    end
  endtask

  task automatic test_drop();
    logic [8:0] exp[8];
    exp[0] = 9'h031; exp[1] = 9'h032; exp[2] = 9'h1C0; exp[3] = 9'h1C1;
    exp[4] = 9'h1C2; exp[5] = 9'h1C3; exp[6] = 9'h033; exp[7] = 9'h1C4;
    do_reset();
    sq.push_back(8'h31); sq.push_back(8'h32);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_checks++; if (s_ready !== 1'b1 || sel !== 1'b0) $display("FAIL drop_grant_s got rdy%0b sel%0b want 1 0", s_ready, sel); else n_pass++;
        for (int k = 0; k < 5; k++) aq.push_back(8'hC0 + 8'(k));
        drive(1'b0, 1'b0);
      end
      if (i == 4) begin
        n_checks++; if (sel !== 1'b1 || a_ready !== 1'b1) $display("FAIL drop_to_a got sel%0b rdy%0b want 1 1", sel, a_ready); else n_pass++;
        sq.push_back(8'h33);
        drive(1'b0, 1'b0);
      end
      if (i > 4 && out_log.size() >= 8) break;
      tick();
    end
    n_checks++; if (out_log.size() != 8) $display("FAIL drop_count got %0d want 8", out_log.size()); else n_pass++;
    for (int i = 0; i < 8 && i < out_log.size(); i++) begin
      n_checks++; if (out_log[i] !== exp[i]) $display("FAIL drop_order[%0d] got %h want %h", i, out_log[i], exp[i]); else n_pass++;
    end

    // Same drop with A idle: the FSM parks in IDLE with sel still at S.
    do_reset();
    sq.push_back(8'h41); sq.push_back(8'h42);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) begin
        n_checks++; if (s_ready !== 1'b0 || a_ready !== 1'b0 || sel !== 1'b0)
          $display("FAIL drop_idle got s%0b a%0b sel%0b want 0 0 0", s_ready, a_ready, sel);
        else n_pass++;
        sq.push_back(8'h43);
        drive(1'b0, 1'b0);
      end
      if (i == 5) begin
        n_checks++; if (s_ready !== 1'b1 || sel !== 1'b0) $display("FAIL drop_regrant got rdy%0b sel%0b want 1 0", s_ready, sel); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) aq.push_back(8'h71 + 8'(k));
    drive(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin @(negedge clk); tick(); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || sel !== 1'b1) $display("FAIL rmid_pre got v%0b sel%0b want 1 1", out_valid, sel); else n_pass++;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_ready !== 1'b0) $display("FAIL rmid_ready_in_reset got %0b want 0", a_ready); else n_pass++;
    out_log.delete();
    tick();
    aq.delete(); a_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (sel !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 1'b0 || a_ready !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL rmid_values got sel%0b v%0b %h src%0b a%0b s%0b want all 0", sel, out_valid, out_data, out_src, a_ready, s_ready);
    else n_pass++;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); @(negedge clk); end
    n_checks++; if (out_log.size() != 0) $display("FAIL rmid_no_emit got %0d words want 0", out_log.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w[16];
    do_reset();
    for (int k = 0; k < 16; k++) begin w[k] = 8'($urandom); aq.push_back(w[k]); end
    drive(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_log.size() >= 16) break;
      tick();
    end
    n_checks++; if (out_log.size() != 16) $display("FAIL b2b_count got %0d want 16", out_log.size()); else n_pass++;
    for (int k = 0; k < 16 && k < out_log.size(); k++) begin
      n_checks++; if (out_log[k] !== {1'b1, w[k]}) $display("FAIL b2b_word[%0d] got %h want %h", k, out_log[k], {1'b1, w[k]}); else n_pass++;
    end
    for (int k = 1; k < 16 && k < acc_cyc.size(); k++) begin
      n_checks++; if (acc_cyc[k] != acc_cyc[0] + k) $display("FAIL b2b_rate[%0d] got cyc %0d want %0d", k, acc_cyc[k], acc_cyc[0] + k); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0] ea[$];
    logic [7:0] es[$];
    logic [8:0] pend;
    logic       pend_v, ov_a, ov_s, src, other_wait, run_src;
    int         run_len, n0, ia, is;
    do_reset();
    a_p = 60; s_p = 60;
    for (int k = 0; k < 40; k++) begin
      ea.push_back(8'($urandom)); aq.push_back(ea[k]);
      es.push_back(8'($urandom)); sq.push_back(es[k]);
    end
    drive(1'b0, 1'b0);
    pend_v = 1'b0; pend = '0; run_len = 0; run_src = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (out_log.size() >= 80) break;
      n_checks++; if (a_ready && s_ready) $display("FAIL rnd_both_ready c%0d got 1 1 want one-hot", i); else n_pass++;
      if (out_valid && !out_ready) begin
        n_checks++; if (a_ready || s_ready) $display("FAIL rnd_stall_ready c%0d got a%0b s%0b want 0 0", i, a_ready, s_ready); else n_pass++;
      end
      if (pend_v) begin
        n_checks++; if (out_valid !== 1'b1 || {out_src, out_data} !== pend)
          $display("FAIL rnd_latency c%0d got v%0b %h want v1 %h", i, out_valid, {out_src, out_data}, pend);
        else n_pass++;
      end
      ov_a = a_valid; ov_s = s_valid;
      n0 = acc_log.size();
      tick();
      out_ready = ($urandom_range(99) < 70);
      pend_v = (acc_log.size() > n0);
      if (pend_v) begin
        pend = acc_log[acc_log.size()-1];
        src = pend[8];
        other_wait = src ? ov_s : ov_a;
        if (run_src != src) begin run_src = src; run_len = 0; end
        run_len = other_wait ? run_len + 1 : 0;
        n_checks++; if (run_len > MAX_BURST) $display("FAIL rnd_burst c%0d got run %0d want <= %0d", i, run_len, MAX_BURST); else n_pass++;
      end
    end
    n_checks++; if (out_log.size() != 80) $display("FAIL rnd_count got %0d want 80", out_log.size()); else n_pass++;
    ia = 0; is = 0;
    foreach (out_log[k]) begin
      if (out_log[k][8]) begin
        n_checks++; if (ia >= 40 || out_log[k][7:0] !== ea[ia]) $display("FAIL rnd_a_order[%0d] got %h", ia, out_log[k][7:0]); else n_pass++;
        ia++;
      end else begin
        n_checks++; if (is >= 40 || out_log[k][7:0] !== es[is]) $display("FAIL rnd_s_order[%0d] got %h", is, out_log[k][7:0]); else n_pass++;
        is++;
      end
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_a_only();
    test_fair();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
